// File: rtl/bus_array_arbiter.sv
// bus_array_arbiter: four requesters write into a 4-entry register array.
// A round-robin pointer picks one writer per cycle. Clear and reset
// zero the array, and any write is acknowledged with a one-cycle ack pulse.
module bus_array_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [3:0]         req,
    input  logic [7:0]         waddr,
    input  logic [4*WIDTH-1:0] wdata,
    output logic [3:0]         ack,
    output logic [3:0]         valid,
    output logic [WIDTH-1:0]   res0,
    output logic [WIDTH-1:0]   res1,
    output logic [WIDTH-1:0]   res2,
    output logic [WIDTH-1:0]   res3
);

    localparam int unsigned NREQ = 4;

    logic [WIDTH-1:0] entry [NREQ];
    logic [1:0]       ptr;

    logic [3:0]       elig_c;
    logic             grant_c;
    logic [1:0]       winner_c;
    logic [1:0]       idx_c;
    logic [1:0]       wsel_c;
    logic [WIDTH-1:0] wval_c;

    // Round-robin search from ptr; a requester being acked this cycle is skipped
    always_comb begin
        elig_c   = req & ~ack;
        grant_c  = 1'b0;
        winner_c = ptr;
        idx_c    = ptr;
        // Walk from the farthest offset down so the nearest eligible requester wins
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            idx_c = ptr + 2'(k);
            if (elig_c[idx_c]) begin
                grant_c  = 1'b1;
                winner_c = idx_c;
            end
        end
        wsel_c = waddr[{winner_c, 1'b0} +: 2];
        wval_c = wdata[WIDTH * 32'(winner_c) +: WIDTH];
    end

    // Array, valid flags, ack pulse and pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREQ); i++) entry[i] <= '0;
            valid <= '0;
            ack   <= '0;
            ptr   <= '0;
        end else if (clear) begin
            for (int i = 0; i < int'(NREQ); i++) entry[i] <= '0;
            valid <= '0;
            ack   <= '0;
        end else if (grant_c) begin
            entry[wsel_c] <= wval_c;
            valid[wsel_c] <= 1'b1;
            ack           <= 4'(1) << winner_c;
            ptr           <= winner_c + 2'd1;
        end else begin
            ack <= '0;
        end
    end

    assign res0 = entry[0];
    assign res1 = entry[1];
    assign res2 = entry[2];
    assign res3 = entry[3];

endmodule

// File: tb/tb_bus_array_arbiter.sv
// Self-checking bench for bus_array_arbiter: a behavioural reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_bus_array_arbiter;

    localparam int unsigned WIDTH = 4;

    logic               clk;
    logic               rst;
    logic               clear;
    logic [3:0]         req;
    logic [7:0]         waddr;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         ack;
    logic [3:0]         valid;
    logic [WIDTH-1:0]   res0, res1, res2, res3;

    int n_cmp = 0;
    int n_bad = 0;

    bus_array_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .req(req), .waddr(waddr),
        .wdata(wdata), .ack(ack), .valid(valid),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: array contents, written flags, last ack, rotation start
    int         m_mem [4];
    logic [3:0] m_valid;
    logic [3:0] m_ack;
    int         m_ptr;

    always @(posedge clk or posedge rst) begin
        int w;
        int a;
        int r;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_mem[i] = 0;
            m_valid = 4'b0;
            m_ack   = 4'b0;
            m_ptr   = 0;
        end else if (clear) begin
            for (int i = 0; i < 4; i++) m_mem[i] = 0;
            m_valid = 4'b0;
            m_ack   = 4'b0;
        end else begin
            w = -1;
            for (int off = 0; off < 4; off++) begin
                r = (m_ptr + off) % 4;
                if (w < 0 && req[r] && !m_ack[r]) w = r;
            end
            m_ack = 4'b0;
            if (w >= 0) begin
                a = int'(waddr[2*w +: 2]);
                m_mem[a]   = int'(wdata[WIDTH*w +: WIDTH]);
                m_valid[a] = 1'b1;
                m_ack[w]   = 1'b1;
                m_ptr      = (w + 1) % 4;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("model_ack", 32'(ack), 32'(m_ack));
        chk("model_valid", 32'(valid), 32'(m_valid));
        chk("model_res", {16'h0, res3, res2, res1, res0},
            {16'h0, 4'(m_mem[3]), 4'(m_mem[2]), 4'(m_mem[1]), 4'(m_mem[0])});
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] seen [4];
        rst = 1'b1; clear = 1'b0; req = 4'b0; waddr = 8'h0; wdata = '0;
        repeat (2) tick();
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_res", {16'h0, res3, res2, res1, res0}, 32'h0);
        rst = 1'b0;
        tick();

        // Single write: requester 0 to entry 2 with A
        req = 4'b0001; waddr = 8'b0000_0010; wdata = 16'h000A;
        tick();
        chk("single_ack", 32'(ack), 32'h1);
        chk("single_res2", 32'(res2), 32'hA);
        chk("single_valid", 32'(valid), 32'h4);
        req = 4'b0;
        tick();
        chk("single_ack_drop", 32'(ack), 32'h0);

        // Round-robin from reset, each requester to its own index, data i+5
        rst = 1'b1; tick(); rst = 1'b0; tick();
        req = 4'b1111; waddr = 8'b11_10_01_00; wdata = 16'h8765;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen[i] = ack;
            req = req & ~ack;
        end
        chk("rr_ack0", 32'(seen[0]), 32'h1);
        chk("rr_ack1", 32'(seen[1]), 32'h2);
        chk("rr_ack2", 32'(seen[2]), 32'h4);
        chk("rr_ack3", 32'(seen[3]), 32'h8);
        chk("rr_res", {16'h0, res3, res2, res1, res0}, 32'h8765);
        chk("rr_valid", 32'(valid), 32'hF);

        // Pointer wrap: requester 0 before requester 3
        req = 4'b1001; waddr = 8'b11_00_00_00; wdata = 16'h2001;
        tick();
        chk("wrap_first", 32'(ack), 32'h1);
        req = 4'b1000;
        tick();
        chk("wrap_second", 32'(ack), 32'h8);
        req = 4'b0;
        chk("wrap_res", {16'h0, res3, res2, res1, res0}, 32'h2761);
        tick();

        // Same-address conflict on entry 1, pointer back at 0
        req = 4'b0011; waddr = 8'b00_00_01_01; wdata = 16'h00C3;
        tick();
        chk("conf_ack0", 32'(ack), 32'h1);
        chk("conf_res1_first", 32'(res1), 32'h3);
        req = 4'b0010;
        tick();
        chk("conf_ack1", 32'(ack), 32'h2);
        chk("conf_res1_last", 32'(res1), 32'hC);
        req = 4'b0;
        tick();

        // Clear beats a simultaneous write; request stays pending
        clear = 1'b1; req = 4'b0100; waddr = 8'b00_10_00_00; wdata = 16'h0900;
        tick();
        chk("clr_res", {16'h0, res3, res2, res1, res0}, 32'h0);
        chk("clr_valid", 32'(valid), 32'h0);
        chk("clr_ack", 32'(ack), 32'h0);
        clear = 1'b0;
        tick();
        chk("clr_after_ack", 32'(ack), 32'h4);
        chk("clr_after_res2", 32'(res2), 32'h9);
        chk("clr_after_valid", 32'(valid), 32'h4);
        req = 4'b0;
        tick();

        // Async reset while requester 1 is being acked
        req = 4'b0010; waddr = 8'b00_00_11_00; wdata = 16'h00E0;
        tick();
        chk("pre_rst_ack", 32'(ack), 32'h2);
        #2 rst = 1'b1; req = 4'b0;
        #1;
        chk("async_ack", 32'(ack), 32'h0);
        chk("async_valid", 32'(valid), 32'h0);
        chk("async_res", {16'h0, res3, res2, res1, res0}, 32'h0);
        tick();
        rst = 1'b0;
        req = 4'b1010; waddr = 8'b11_00_01_00; wdata = 16'h5040;
        tick();
        chk("post_rst_first", 32'(ack), 32'h2);
        req = 4'b1000;
        tick();
        chk("post_rst_second", 32'(ack), 32'h8);
        req = 4'b0;
        chk("post_rst_res", {16'h0, res3, res2, res1, res0}, 32'h5040);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_array_arbiter.md
BUS_ARRAY_ARBITER -- requirements
Module: bus_array_arbiter

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of each array entry and each write datum.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: clear  input  1  synchronous clear of all array entries.
REQ-006 Port: req  input  4  req[i] = requester i wants to write one entry.
REQ-007 Port: waddr  input  8  target entry index for requester i at bits [2i+1:2i].
REQ-008 Port: wdata  input  4*WIDTH  write data for requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-009 Port: ack  output  4  ack[i] high for one cycle when requester i's write has been committed.
REQ-010 Port: valid  output  4  valid[k] = entry k written since the last reset or clear.
REQ-011 Port: res0..res3  output  WIDTH each  registered contents of entries 0..3.

Function
REQ-012 Storage: 4 entries of WIDTH bits, all registers; resK drives entry K directly, with no combinational path from any input.
REQ-013 Eligibility per cycle: elig = req & ~ack; a requester whose ack is currently high is excluded that cycle, which prevents a double write while it drops req.
REQ-014 Arbitration: round-robin over elig, using a 2-bit pointer ptr.
  - Search order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - The first eligible requester is the winner.
REQ-015 Commit, on the rising edge with at least one eligible requester and clear low:
  - entry[waddr(winner)] <= wdata(winner);
  - valid[waddr(winner)] <= 1;
  - ack <= one-hot(winner);
  - ptr <= winner+1 mod 4 (3 wraps to 0).
REQ-016 Idle edge (no eligible requester, clear low): entries, valid and ptr hold; ack <= 0.
REQ-017 At most one entry is written per cycle; ack is always zero or one-hot.
REQ-018 Latency: with req high before edge N, the write is granted at edge N. New data on resK and ack[i] both appear after edge N, in the same cycle.
REQ-019 A requester holds req, waddr and wdata stable until it samples ack high. Its req value during the ack cycle is ignored (REQ-013).
REQ-020 Same-address conflict: two requesters targeting the same entry are serialized by arbitration. The later winner's data persists.
REQ-021 Clear: on an edge with clear high:
  - all entries <= 0 and valid <= 0;
  - ack <= 0 and no write commits;
  - ptr holds;
  - pending requests remain pending and compete on the next edge with clear low.
REQ-022 Clear has priority over any simultaneous write.
REQ-023 A req dropped before being granted is withdrawn without side effects.

Reset
REQ-024 While rst is high, independent of clk:
  - entries = 0, res0..res3 = 0;
  - valid = 4'b0000, ack = 4'b0000;
  - ptr = 0.
REQ-025 Reset asserted mid-operation discards any in-flight grant. ack is forced low immediately and no write commits on the edge coinciding with rst.
REQ-026 After rst deasserts, the first arbitration starts from requester 0.

Verification
REQ-027 The bench SHALL cover the following directed scenarios:
  - Single write: req=0001, waddr[1:0]=2, wdata[3:0]=4'hA. Result: one cycle later res2=A, valid=0100, ack=0001 for exactly one cycle.
  - Round-robin from reset: req=1111, each requester targets its own index with data i+5. Result: acks 0001, 0010, 0100, 1000 on consecutive grant cycles, each requester dropping req on ack; final res0..3 = 5,6,7,8, valid=1111.
  - Pointer wrap: after requester 3 is granted, req=1001. Result: requester 0 is granted before requester 3.
  - Same-address conflict: req=0011, both target entry 1, data 3 and C, ptr=0. Result: res1=3 then res1=C.
  - Clear vs write: clear=1 with req=0100 in the same cycle. Result: all res=0, valid=0, ack=0; requester 2 is acked on the next edge after clear drops.
  - Async reset mid-grant: rst asserted between edges while ack=0010. Result: ack, valid and res go to 0 immediately; after release, req=1010 grants requester 1 first.
